// File: rtl/uart_pkg.sv
// uart_pkg: shared parity constants, transmitter FSM states and width helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  function automatic int log2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_sync_fifo.sv
// uart_tx_sync_fifo: first-word fall-through synchronous FIFO with wrap-bit pointers
module uart_tx_sync_fifo
  import uart_pkg::*;
#(
  parameter int Depth = 16,
  parameter int Width = 8,
  localparam int AW = log2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  logic [Width-1:0] mem [Depth];
  logic [AW:0] wp, rp;
  logic do_wr, do_rd;
  assign count = wp - rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wp <= wp + (AW+1)'(1);
      if (do_rd) rp <= rp + (AW+1)'(1);
      overflow <= wr_en && full;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N/8E/8O UART transmitter with 1 or 2 stop bits
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 100000000,
  parameter int Baud = 3000000,
  parameter int FifoDepth = 16,
  parameter int ParityMode = 0,
  parameter int StopBits = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic [log2(FifoDepth):0]   fifo_count,
  output logic                       overflow,
  output logic                       TxD,
  output logic                       TxD_busy
);
  localparam int DIV = (ClkFrequency + Baud / 2) / Baud;
  localparam int CW = log2(DIV) < 1 ? 1 : log2(DIV);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] shift, shift_n, head;
  logic [2:0] idx, idx_n;
  logic par, par_n, stop2, stop2_n, txd_n, empty, pop, tick, last_stop;
  uart_tx_sync_fifo #(.Depth(FifoDepth), .Width(8)) fifo (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(pop), .rd_data(head),
    .count(fifo_count), .full(full), .empty(empty), .overflow(overflow)
  );
  assign tick = cnt == CW'(DIV - 1);
  assign last_stop = StopBits == 1 || stop2;
  assign TxD_busy = state != IDLE || !empty;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = empty ? IDLE : START;
        pop = !empty;
      end
      START: state_n = tick ? DATA : START;
      DATA: state_n = tick && idx == 3'd7 ? (ParityMode != PAR_NONE ? PARITY : STOP) : DATA;
      PARITY: state_n = tick ? STOP : PARITY;
      STOP: if (tick && last_stop) begin
        state_n = empty ? IDLE : START;
        pop = !empty;
      end
      default: state_n = IDLE;
    endcase
    cnt_n = state == IDLE || tick ? '0 : cnt + CW'(1);
    shift_n = pop ? head : state == DATA && tick ? shift >> 1 : shift;
    idx_n = state != DATA ? 3'd0 : tick ? idx + 3'd1 : idx;
    par_n = pop ? ^head ^ (ParityMode == PAR_ODD) : par;
    stop2_n = state_n != STOP ? 1'b0 : state == STOP && tick ? 1'b1 : stop2;
    txd_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shift <= '0;
      idx <= '0;
      par <= 1'b0;
      stop2 <= 1'b0;
      TxD <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shift <= shift_n;
      idx <= idx_n;
      par <= par_n;
      stop2 <= stop2_n;
      TxD <= txd_n;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench decoding serial frames from three parity/stop configurations
module tb_uart_tx_fifo;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0;
  logic rst;
  logic wr_en [3];
  logic [7:0] wr_data [3];
  logic full [3];
  logic [4:0] cnt [3];
  logic ovf [3];
  logic txd [3];
  logic busy [3];
  bq_t q [3];
  int starts[$];
  int cmp = 0, bad = 0, cyc = 0, epoch = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : inst
    uart_tx_fifo #(.ClkFrequency(100000000), .Baud(3000000), .FifoDepth(16), .ParityMode(g), .StopBits(g == 0 ? 2 : 1)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en[g]), .wr_data(wr_data[g]), .full(full[g]),
      .fifo_count(cnt[g]), .overflow(ovf[g]), .TxD(txd[g]), .TxD_busy(busy[g])
    );
    initial forever begin : mon
      logic [7:0] b, e;
      logic p, ok;
      int ep, st;
      @(negedge txd[g]);
      ep = epoch;
      st = cyc;
      repeat (16) @(negedge clk);
      ok = txd[g] == 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (33) @(negedge clk);
        b[i] = txd[g];
      end
      p = 1'b0;
      if (g != 0) begin
        repeat (33) @(negedge clk);
        p = txd[g];
      end
      for (int i = 0; i < (g == 0 ? 2 : 1); i++) begin
        repeat (33) @(negedge clk);
        ok = ok && txd[g];
      end
      if (ep == epoch) begin
        if (q[g].size() == 0) chk($sformatf("unexpected_frame%0d", g), {24'd0, b}, 32'hFFFF_FFFF);
        else begin
          e = q[g].pop_front();
          chk($sformatf("byte%0d", g), {24'd0, b}, {24'd0, e});
          chk($sformatf("framing%0d", g), {31'd0, ok}, 32'd1);
          if (g != 0) chk($sformatf("parity%0d", g), {31'd0, p}, {31'd0, ^e ^ (g == 2)});
          if (g == 0) starts.push_back(st);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic put(input int g, input logic [7:0] b, input bit push);
    wr_en[g] = 1'b1;
    wr_data[g] = b;
    if (push) q[g].push_back(b);
    @(negedge clk);
    wr_en[g] = 1'b0;
  endtask
  task automatic wait_idle(input int g, input int lim);
    int t = 0;
    while ((busy[g] !== 1'b0 || q[g].size() != 0) && t < lim) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
    chk($sformatf("idle_timeout%0d", g), {31'd0, busy[g]}, 32'd0);
  endtask
  initial begin
    int viol;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en[i] = 1'b0;
      wr_data[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd[0]}, 32'd1);
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_full", {31'd0, full[0]}, 32'd0);
    chk("rst_count", {27'd0, cnt[0]}, 32'd0);
    chk("rst_ovf", {31'd0, ovf[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    put(0, 8'h55, 1'b1);
    chk("t1_count_n1", {27'd0, cnt[0]}, 32'd1);
    chk("t1_busy_n1", {31'd0, busy[0]}, 32'd1);
    chk("t1_txd_n1", {31'd0, txd[0]}, 32'd1);
    @(negedge clk);
    chk("t1_start_n2", {31'd0, txd[0]}, 32'd0);
    chk("t1_count_n2", {27'd0, cnt[0]}, 32'd0);
    repeat (32) @(negedge clk);
    chk("t1_start_n34", {31'd0, txd[0]}, 32'd0);
    @(negedge clk);
    chk("t1_bit0_n35", {31'd0, txd[0]}, 32'd1);
    repeat (329) @(negedge clk);
    chk("t1_busy_n364", {31'd0, busy[0]}, 32'd1);
    chk("t1_stop_n364", {31'd0, txd[0]}, 32'd1);
    @(negedge clk);
    chk("t1_busy_n365", {31'd0, busy[0]}, 32'd0);
    wr_en[1] = 1'b1;
    wr_data[1] = 8'h07;
    q[1].push_back(8'h07);
    wr_en[2] = 1'b1;
    wr_data[2] = 8'h00;
    q[2].push_back(8'h00);
    @(negedge clk);
    wr_en[1] = 1'b0;
    wr_en[2] = 1'b0;
    repeat (309) @(negedge clk);
    chk("t2_even_parity", {31'd0, txd[1]}, 32'd1);
    chk("t2_odd_parity", {31'd0, txd[2]}, 32'd1);
    repeat (54) @(negedge clk);
    chk("t2_busy_n364", {31'd0, busy[1]}, 32'd1);
    @(negedge clk);
    chk("t2_busy_n365", {31'd0, busy[1]}, 32'd0);
    chk("t2_busy_odd_n365", {31'd0, busy[2]}, 32'd0);
    starts.delete();
    put(0, 8'hA1, 1'b1);
    chk("t3_count_n1", {27'd0, cnt[0]}, 32'd1);
    put(0, 8'hB2, 1'b1);
    chk("t3_count_n2", {27'd0, cnt[0]}, 32'd1);
    put(0, 8'hC3, 1'b1);
    chk("t3_count_n3", {27'd0, cnt[0]}, 32'd2);
    repeat (362) @(negedge clk);
    chk("t3_count_n365", {27'd0, cnt[0]}, 32'd1);
    repeat (363) @(negedge clk);
    chk("t3_count_n728", {27'd0, cnt[0]}, 32'd0);
    wait_idle(0, 1000);
    chk("t3_frames", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      chk("t3_gap1", starts[1] - starts[0], 32'd363);
      chk("t3_gap2", starts[2] - starts[1], 32'd363);
    end
    put(0, 8'h10, 1'b1);
    for (int i = 1; i < 16; i++) put(0, 8'h10 + 8'(i), 1'b1);
    chk("t4_count15", {27'd0, cnt[0]}, 32'd15);
    chk("t4_notfull", {31'd0, full[0]}, 32'd0);
    repeat (348) @(negedge clk);
    chk("t4_count_prepop", {27'd0, cnt[0]}, 32'd15);
    put(0, 8'h20, 1'b1);
    chk("t6_count_wr_pop", {27'd0, cnt[0]}, 32'd15);
    chk("t6_no_ovf", {31'd0, ovf[0]}, 32'd0);
    put(0, 8'h21, 1'b1);
    chk("t4_count16", {27'd0, cnt[0]}, 32'd16);
    chk("t4_full", {31'd0, full[0]}, 32'd1);
    put(0, 8'hE0, 1'b0);
    chk("t4_ovf1", {31'd0, ovf[0]}, 32'd1);
    chk("t4_count_hold", {27'd0, cnt[0]}, 32'd16);
    put(0, 8'hE1, 1'b0);
    chk("t4_ovf2", {31'd0, ovf[0]}, 32'd1);
    @(negedge clk);
    chk("t4_ovf_clear", {31'd0, ovf[0]}, 32'd0);
    chk("t4_still_full", {31'd0, full[0]}, 32'd1);
    wait_idle(0, 8000);
    for (int i = 0; i < 6; i++) put(0, 8'h61 + 8'(i), 1'b1);
    repeat (174) @(negedge clk);
    rst = 1'b1;
    epoch++;
    q[0].delete();
    @(negedge clk);
    rst = 1'b0;
    chk("t5_txd", {31'd0, txd[0]}, 32'd1);
    chk("t5_count", {27'd0, cnt[0]}, 32'd0);
    chk("t5_busy", {31'd0, busy[0]}, 32'd0);
    viol = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) viol++;
    end
    chk("t5_quiet", viol, 32'd0);
    put(0, 8'h3C, 1'b1);
    wait_idle(0, 1000);
    for (int g = 0; g < 3; g++) chk($sformatf("drain%0d", g), q[g].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
